hazard_spike_scheduler: RTL and testbench
=========================================

Name: hazard_spike_scheduler

Overview:
Downstream stage of the hazard grid encoder. Accepts one 32-cell occupancy frame per handshake (vec1 = cells 0-15, vec2 = cells 16-31; 4 rows x 8 columns, row-major) and emits a window of NUM_STEPS spike vectors for the SNN input layer.
Per-cell age history encodes recency as spike rate:
- Currently occupied cells fire every step.
- Recently vacated cells fire at progressively lower rates.
- Stale cells are silent.

Parameters:
NUM_CELLS, 32, grid cells. Fixed to vec2:vec1 width.
NUM_STEPS, 8, spike beats per frame window. Must be at least 2.
AGE_W, 2, age counter width. MAX_AGE = 2^AGE_W - 1 means silent / no history.
STEP_W, $clog2(NUM_STEPS), step index width.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
frame_valid  in  1  occupancy frame offered
frame_ready  out  1  block can accept a frame (IDLE only)
vec1  in  16  occupancy of cells 0-15
vec2  in  16  occupancy of cells 16-31
hist_clr  in  1  single-cycle request to wipe age history
spike_valid  out  1  spike_vec / step_idx valid
spike_ready  in  1  downstream accepts current beat
spike_vec  out  32  spikes; bit c = cell c
step_idx  out  STEP_W  beat number within the window
spike_last  out  1  high on the beat with step_idx = NUM_STEPS-1

Behaviour:
- Reset, synchronous, wins over everything:
  - state = IDLE.
  - All age[c] = MAX_AGE; phase counters 0; hist_clr pending flag 0.
  - spike_valid, spike_vec, step_idx, spike_last = 0.
  - frame_ready = 1 in the first cycle after rst deasserts.
  - Reset mid-window abandons the window with no further beats.
- States: IDLE, EMIT.
- IDLE:
  - frame_ready = 1, spike_valid = 0.
  - Capture on frame_valid && frame_ready. Let occ = {vec2, vec1}. For each cell c:
    - if occ[c] = 1: age[c] = 0;
    - else if clear is effective: age[c] = MAX_AGE;
    - else: age[c] = min(age[c] + 1, MAX_AGE), saturating.
  - Clear is effective when hist_clr is high this cycle or the pending flag is set. The pending flag clears on capture.
  - Also on capture: all phase[c] = 0, step = 0, go to EMIT.
  - hist_clr in IDLE without frame_valid sets all ages to MAX_AGE next cycle.
- EMIT:
  - frame_ready = 0; frame_valid is ignored and not buffered.
  - hist_clr here sets the pending flag only; the current window is unaffected.
  - spike_valid = 1. First beat appears the cycle after capture (latency 1).
  - spike_vec[c] = 1 iff age[c] < MAX_AGE and phase[c] = 0. period(c) = age[c] + 1.
  - On spike_valid && spike_ready:
    - each phase[c] = (phase[c] + 1 == period(c)) ? 0 : phase[c] + 1;
    - step increments.
    - If step was NUM_STEPS-1, return to IDLE: spike_valid = 0 and frame_ready = 1 next cycle.
  - While spike_ready = 0: spike_vec, step_idx and spike_last are held stable.
- Ages change only at capture, hist_clr in IDLE, or reset. They are never changed during EMIT.
- Throughput: one window per NUM_STEPS + 1 cycles with no backpressure.

Decomposition:
- Shared package contents:
  - NUM_CELLS, GRID_ROWS = 4, GRID_COLS = 8.
  - State enum {IDLE, EMIT}.
  - Age and step widths.
  - Cell-index-to-vec mapping constant (16 cells per vec).
- One natural sub-module: hazard_cell_rate_gen, instantiated NUM_CELLS times.
  - Holds age and phase for one cell.
  - Inputs: capture, occ bit, clear, advance.
  - Output: spike.
- The top level holds the FSM, step counter, pending flag and handshakes.

Test Plan:
1. Reset, then frame vec1 = 16'h0001, vec2 = 0, spike_ready = 1 -> 8 beats of spike_vec = 32'h00000001, step_idx 0..7, spike_last only on step 7, frame_ready = 1 the cycle after.
2. Frame with cell 0 occupied, then an empty frame -> cell 0 age 1; spike_vec bit 0 = 1,0,1,0,1,0,1,0 across steps 0-7.
3. Third frame empty -> cell 0 age 2 fires at steps 0,3,6. Fourth frame empty -> age 3, all 8 beats zero. Frame vec2 = 16'h8000 -> bit 31 fires every beat.
4. Backpressure: spike_ready low 3 cycles at step 2 -> spike_vec and step_idx held; exactly 8 accepted beats, no duplicates or skips.
5. hist_clr pulse during EMIT, then empty frame -> whole window zero (pending clear applied). hist_clr coincident with a frame having vec1 = 16'h0002 -> only bit 1 fires, every beat.
6. rst asserted at step 4 -> next cycle spike_valid = 0 and frame_ready = 1. Next empty frame yields all-zero spikes (history wiped).

Source files
------------

// File: rtl/hazard_spike_scheduler_pkg.sv
// rtl/hazard_spike_scheduler_pkg.sv - shared constants, types and helpers for the hazard spike scheduler
package hazard_spike_scheduler_pkg;

   localparam int GRID_ROWS     = 4;
   localparam int GRID_COLS     = 8;
   localparam int NUM_CELLS     = GRID_ROWS * GRID_COLS;
   localparam int CELLS_PER_VEC = 16;
   localparam int NUM_STEPS     = 8;
   localparam int AGE_W         = 2;
   localparam int STEP_W        = $clog2(NUM_STEPS);

   typedef logic [AGE_W-1:0]  age_t;
   typedef logic [STEP_W-1:0] step_t;

   localparam age_t MAX_AGE = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   function automatic age_t age_sat_inc(input age_t a);
      return (a == MAX_AGE) ? MAX_AGE : age_t'(a + 1'b1);
   endfunction

endpackage

// File: rtl/hazard_spike_scheduler_cell.sv
// rtl/hazard_spike_scheduler_cell.sv - per-cell age history and rate-coded spike phase
module hazard_cell_rate_gen
   import hazard_spike_scheduler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic capture,
   input  logic occ,
   input  logic clear,
   input  logic advance,
   output logic spike
);

   age_t r_age;
   age_t r_phase;

   // Phase never exceeds age, so wrapping at phase == age gives period age + 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_age   <= MAX_AGE;
         r_phase <= '0;
      end else if (capture) begin
         r_phase <= '0;
         if (occ)
            r_age <= '0;
         else if (clear)
            r_age <= MAX_AGE;
         else
            r_age <= age_sat_inc(r_age);
      end else if (clear) begin
         r_age <= MAX_AGE;
      end else if (advance) begin
         r_phase <= (r_phase == r_age) ? '0 : age_t'(r_phase + 1'b1);
      end
   end

   assign spike = (r_age != MAX_AGE) && (r_phase == '0);

endmodule

// File: rtl/hazard_spike_scheduler.sv
// rtl/hazard_spike_scheduler.sv - frame capture FSM emitting NUM_STEPS rate-coded spike beats per frame
module hazard_spike_scheduler
   import hazard_spike_scheduler_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_valid,
   output logic                     frame_ready,
   input  logic [CELLS_PER_VEC-1:0] vec1,
   input  logic [CELLS_PER_VEC-1:0] vec2,
   input  logic                     hist_clr,
   output logic                     spike_valid,
   input  logic                     spike_ready,
   output logic [NUM_CELLS-1:0]     spike_vec,
   output logic [STEP_W-1:0]        step_idx,
   output logic                     spike_last
);

   state_t r_state;
   state_t w_state_nxt;
   step_t  r_step;
   logic   r_pend;

   logic [NUM_CELLS-1:0] w_occ;
   logic [NUM_CELLS-1:0] w_spk;
   logic                 w_capture;
   logic                 w_clear;
   logic                 w_advance;
   logic                 w_last;

   assign w_occ  = {vec2, vec1};
   assign w_last = (r_step == step_t'(NUM_STEPS - 1));

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      frame_ready = 1'b0;
      spike_valid = 1'b0;
      w_capture   = 1'b0;
      w_clear     = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            frame_ready = 1'b1;
            w_clear     = hist_clr || r_pend;
            w_capture   = frame_valid;
            if (frame_valid)
               w_state_nxt = ST_EMIT;
         end
         ST_EMIT: begin
            spike_valid = 1'b1;
            w_advance   = spike_ready;
            if (spike_ready && w_last)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A clear seen mid-window is deferred so the window in flight stays intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_step <= '0;
         r_pend <= 1'b0;
      end else if (w_capture) begin
         r_step <= '0;
         r_pend <= 1'b0;
      end else begin
         if (w_advance)
            r_step <= step_t'(r_step + 1'b1);
         if ((r_state == ST_EMIT) && hist_clr)
            r_pend <= 1'b1;
      end
   end

   for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
      hazard_cell_rate_gen u_cell (
         .clk     (clk),
         .rst     (rst),
         .capture (w_capture),
         .occ     (w_occ[c]),
         .clear   (w_clear),
         .advance (w_advance),
         .spike   (w_spk[c])
      );
   end

   assign spike_vec  = spike_valid ? w_spk : '0;
   assign step_idx   = r_step;
   assign spike_last = spike_valid && w_last;

endmodule

// File: tb/tb_hazard_spike_scheduler.sv
// tb/tb_hazard_spike_scheduler.sv - scoreboard bench for the hazard spike scheduler
module tb_hazard_spike_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_valid = 1'b0;
   logic        frame_ready;
   logic [15:0] vec1 = '0;
   logic [15:0] vec2 = '0;
   logic        hist_clr = 1'b0;
   logic        spike_valid;
   logic        spike_ready = 1'b0;
   logic [31:0] spike_vec;
   logic [2:0]  step_idx;
   logic        spike_last;

   always #5 clk = ~clk;

   hazard_spike_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .vec1        (vec1),
      .vec2        (vec2),
      .hist_clr    (hist_clr),
      .spike_valid (spike_valid),
      .spike_ready (spike_ready),
      .spike_vec   (spike_vec),
      .step_idx    (step_idx),
      .spike_last  (spike_last)
   );

   typedef struct packed {
      logic [31:0] vec;
      logic [2:0]  step;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    model_age[32];
   bit    model_pend = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_wipe();
      for (int c = 0; c < 32; c++) model_age[c] = 3;
   endfunction

   // Ages follow the recency rules; cell fires on steps that are multiples of age+1.
   function automatic void model_capture(input logic [31:0] occ, input bit clr);
      beat_t b;
      bit    eff;
      eff = clr || model_pend;
      for (int c = 0; c < 32; c++) begin
         if (occ[c])      model_age[c] = 0;
         else if (eff)    model_age[c] = 3;
         else if (model_age[c] < 3) model_age[c] = model_age[c] + 1;
      end
      model_pend = 1'b0;
      for (int s = 0; s < 8; s++) begin
         b.vec = '0;
         for (int c = 0; c < 32; c++)
            if (model_age[c] < 3 && (s % (model_age[c] + 1)) == 0) b.vec[c] = 1'b1;
         b.step = s[2:0];
         b.last = (s == 7);
         exp_q.push_back(b);
      end
   endfunction

   beat_t held;
   bit    prev_stall = 1'b0;
   bit    idle_next = 1'b0;

   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         prev_stall = 1'b0;
         idle_next  = 1'b0;
      end else begin
         if (idle_next) begin
            check("idle_after_last", {frame_ready, spike_valid}, 2'b10);
            idle_next = 1'b0;
         end
         if (spike_valid && prev_stall)
            check("hold_under_stall", {spike_vec, step_idx, spike_last}, held);
         if (spike_valid && spike_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_beat actual=%0h expected=none", {spike_vec, step_idx, spike_last});
            end else begin
               b = exp_q.pop_front();
               check("beat", {spike_vec, step_idx, spike_last}, b);
               if (b.last) idle_next = 1'b1;
            end
         end
         prev_stall = spike_valid && !spike_ready;
         held       = {spike_vec, step_idx, spike_last};
      end
   end

   task automatic drive_window(input logic [15:0] v1, input logic [15:0] v2,
                               input bit clr_with, input bit clr_mid, input int mode);
      int stalls;
      bit done;
      stalls = 0;
      done   = 1'b0;
      for (int i = 0; i < 50 && !frame_ready; i++) begin
         @(posedge clk);
         #1;
      end
      check("frame_ready_before_frame", frame_ready, 1);
      vec1 = v1;
      vec2 = v2;
      frame_valid = 1'b1;
      hist_clr = clr_with;
      model_capture({v2, v1}, clr_with);
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      hist_clr = 1'b0;
      vec1 = 16'($urandom);
      vec2 = 16'($urandom);
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         case (mode)
            0: spike_ready = 1'b1;
            1: begin
               spike_ready = ($urandom_range(0, 2) != 0);
               frame_valid = ($urandom_range(0, 1) != 0);
            end
            default: begin
               if (step_idx == 3'd2 && stalls < 3) begin
                  spike_ready = 1'b0;
                  stalls++;
               end else begin
                  spike_ready = 1'b1;
               end
            end
         endcase
         if (clr_mid && cyc == 1) begin
            hist_clr = 1'b1;
            model_pend = 1'b1;
         end else begin
            hist_clr = 1'b0;
         end
         @(posedge clk);
         #1;
         if (frame_ready) done = 1'b1;
      end
      frame_valid = 1'b0;
      hist_clr = 1'b0;
      spike_ready = 1'b1;
      check("window_done", done, 1);
      check("all_beats_consumed", exp_q.size(), 0);
      if (mode == 2) check("stall_cycles", stalls, 3);
   endtask

   task automatic reset_mid_window(input logic [15:0] v1, input logic [15:0] v2);
      bit hit;
      hit = 1'b0;
      vec1 = v1;
      vec2 = v2;
      frame_valid = 1'b1;
      model_capture({v2, v1}, 1'b0);
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      spike_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
         if (spike_valid && step_idx == 3'd4) hit = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("reached_step4", hit, 1);
      rst = 1'b1;
      spike_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      model_wipe();
      model_pend = 1'b0;
      check("post_rst_spike_valid", spike_valid, 0);
      check("post_rst_frame_ready", frame_ready, 1);
      spike_ready = 1'b1;
   endtask

   initial begin
      model_wipe();
      repeat (3) @(posedge clk);
      #1;
      check("rst_spike_valid", spike_valid, 0);
      check("rst_spike_vec", spike_vec, 0);
      check("rst_step_idx", step_idx, 0);
      check("rst_spike_last", spike_last, 0);
      rst = 1'b0;
      check("rst_frame_ready", frame_ready, 1);
      spike_ready = 1'b1;

      drive_window(16'h0001, 16'h0000, 1'b0, 1'b0, 0);
      drive_window(16'h0000, 16'h0000, 1'b0, 1'b0, 0);
      drive_window(16'h0000, 16'h0000, 1'b0, 1'b0, 0);
      drive_window(16'h0000, 16'h0000, 1'b0, 1'b0, 0);
      drive_window(16'h0000, 16'h8000, 1'b0, 1'b0, 0);
      drive_window(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 2);
      drive_window(16'h00F0, 16'h0000, 1'b0, 1'b1, 0);
      drive_window(16'h0000, 16'h0000, 1'b0, 1'b0, 0);
      drive_window(16'h0002, 16'h0000, 1'b1, 1'b0, 0);
      reset_mid_window(16'hFFFF, 16'hFFFF);
      drive_window(16'h0000, 16'h0000, 1'b0, 1'b0, 0);

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            hist_clr = 1'b1;
            model_wipe();
            @(posedge clk);
            #1;
            hist_clr = 1'b0;
         end
         drive_window(16'($urandom), 16'($urandom),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 1);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
